bus_trim_sequencer: RTL and testbench



---
 rtl/bus_trim_sequencer_pkg.sv | 7 +
 rtl/bus_trim_sequencer_if.sv | 21 ++
 rtl/bus_trim_sequencer_trim_cycle_timer.sv | 17 +
 rtl/bus_trim_sequencer.sv | 93 +++++++++
 tb/tb_bus_trim_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_trim_sequencer_pkg.sv
// mopshub_trim_pkg: sequencer state encoding, default timing constants and bus limit
package mopshub_trim_pkg;
  localparam int MAX_BUSES = 32;
  localparam int DEF_SETTLE_CYC = 16;
  localparam int DEF_TIMEOUT_CYC = 4096;
  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_REQ, ST_WAIT, ST_NEXT, ST_DONE} trim_seq_state_t;
endpackage

// File: rtl/bus_trim_sequencer_if.sv
// bus_trim_sequencer_if: trim control/status bundle; master = sequencer (drives power/ack/status), slave = init FSM + trim engine
interface bus_trim_sequencer_if import mopshub_trim_pkg::*; #(parameter int CNT_W = 5);
  logic osc_auto_trim_mopshub;
  logic start_trim;
  logic trim_done_bus;
  logic power_bus_en;
  logic [CNT_W-1:0] power_bus_cnt;
  logic start_trim_ack;
  logic end_trim_bus;
  logic done_trim_osc;
  logic trim_timeout_err;
  logic [MAX_BUSES-1:0] bus_fail_mask;
  modport master (
    input osc_auto_trim_mopshub, start_trim, trim_done_bus,
    output power_bus_en, power_bus_cnt, start_trim_ack, end_trim_bus, done_trim_osc, trim_timeout_err, bus_fail_mask
  );
  modport slave (
    output osc_auto_trim_mopshub, start_trim, trim_done_bus,
    input power_bus_en, power_bus_cnt, start_trim_ack, end_trim_bus, done_trim_osc, trim_timeout_err, bus_fail_mask
  );
endinterface

// File: rtl/bus_trim_sequencer_trim_cycle_timer.sv
// trim_cycle_timer: saturating loadable down-counter (clk, rst async low, clr, load+load_val, en) flagging expired at zero
module trim_cycle_timer #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : clr ? '0 : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == '0;
endmodule

// File: rtl/bus_trim_sequencer.sv
// bus_trim_sequencer: powers each bus, settles, requests a trim, waits done/timeout, then flags completion (clk, rst async low, bus = master modport)
module bus_trim_sequencer import mopshub_trim_pkg::*; #(
  parameter int N_BUSES = 7,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic rst,
  bus_trim_sequencer_if.master bus
);
  localparam int SW = $clog2(SETTLE_CYC) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  trim_seq_state_t state_q;
  logic pwr_q, ack_q, end_q, done_q, err_q;
  logic [CNT_W-1:0] idx_q;
  logic [MAX_BUSES-1:0] mask_q;
  logic settle_exp, to_exp, go, start, last, abort;
  assign start = (state_q == ST_IDLE || state_q == ST_DONE) && bus.start_trim;
  assign go = start && bus.osc_auto_trim_mopshub;
  assign last = idx_q == CNT_W'(N_BUSES - 1);
  assign abort = !bus.osc_auto_trim_mopshub && (state_q == ST_SETTLE || state_q == ST_REQ || state_q == ST_WAIT);
  // Settle timer is armed on the cycle that enters SETTLE so it expires after exactly SETTLE_CYC cycles in SETTLE
  trim_cycle_timer #(.W(SW)) u_settle (
    .clk(clk), .rst(rst),
    .clr(state_q != ST_SETTLE), .load(go || state_q == ST_NEXT), .en(state_q == ST_SETTLE),
    .load_val(SW'(SETTLE_CYC - 1)), .expired(settle_exp)
  );
  // Armed in REQ with TIMEOUT_CYC-2 so the last WAIT cycle is ack+TIMEOUT_CYC-1 and end_trim_bus lands at ack+TIMEOUT_CYC
  trim_cycle_timer #(.W(TW)) u_timeout (
    .clk(clk), .rst(rst),
    .clr(state_q != ST_WAIT), .load(state_q == ST_REQ), .en(state_q == ST_WAIT),
    .load_val(TW'(TIMEOUT_CYC - 2)), .expired(to_exp)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_IDLE;
      pwr_q <= 1'b0;
      ack_q <= 1'b0;
      end_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
      mask_q <= '0;
    end else begin
      ack_q <= 1'b0;
      end_q <= 1'b0;
      if (abort) begin
        state_q <= ST_DONE;
        pwr_q <= 1'b0;
        done_q <= 1'b1;
      end else if (start) begin
        state_q <= go ? ST_SETTLE : ST_DONE;
        pwr_q <= go;
        done_q <= !go;
        err_q <= 1'b0;
        idx_q <= '0;
        mask_q <= '0;
      end else
        case (state_q)
          ST_SETTLE: if (settle_exp) begin
            state_q <= ST_REQ;
            ack_q <= 1'b1;
          end
          ST_REQ: state_q <= ST_WAIT;
          ST_WAIT: if (bus.trim_done_bus || to_exp) begin
            state_q <= ST_NEXT;
            pwr_q <= 1'b0;
            end_q <= 1'b1;
            if (!bus.trim_done_bus) begin
              mask_q[idx_q] <= 1'b1;
              err_q <= 1'b1;
            end
          end
          ST_NEXT: if (last) begin
            state_q <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            state_q <= ST_SETTLE;
            pwr_q <= 1'b1;
            idx_q <= idx_q + CNT_W'(1);
          end
          default: ;
        endcase
    end
  assign bus.power_bus_en = pwr_q;
  assign bus.power_bus_cnt = idx_q;
  assign bus.start_trim_ack = ack_q;
  assign bus.end_trim_bus = end_q;
  assign bus.done_trim_osc = done_q;
  assign bus.trim_timeout_err = err_q;
  assign bus.bus_fail_mask = mask_q;
endmodule

// File: tb/tb_bus_trim_sequencer.sv
// tb_bus_trim_sequencer: scoreboard bench for bus_trim_sequencer with N_BUSES=3, SETTLE_CYC=4, TIMEOUT_CYC=20
module tb_bus_trim_sequencer;
  typedef struct packed {int cyc; logic is_end; logic [4:0] cnt;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  bit pwr_seen, ack_seen;
  ev_t exp_q[$];
  ev_t got, e;
  bus_trim_sequencer_if #(.CNT_W(5)) b ();
  bus_trim_sequencer #(.N_BUSES(3), .SETTLE_CYC(4), .TIMEOUT_CYC(20), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (rst) begin
    if (b.power_bus_en) pwr_seen = 1'b1;
    if (b.start_trim_ack) ack_seen = 1'b1;
    if (b.start_trim_ack && b.end_trim_bus) begin
      tests++; fails++;
      $display("FAIL ack_end_overlap at cycle %0d", cyc);
    end
    if (b.start_trim_ack || b.end_trim_bus) begin
      got = '{cyc: cyc, is_end: b.end_trim_bus, cnt: b.power_bus_cnt};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event got cyc=%0d end=%b cnt=%0d, none expected", got.cyc, got.is_end, got.cnt);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          fails++;
          $display("FAIL event got cyc=%0d end=%b cnt=%0d exp cyc=%0d end=%b cnt=%0d", got.cyc, got.is_end, got.cnt, e.cyc, e.is_end, e.cnt);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask
  task automatic pulse_done(input int c);
    goto(c);
    b.trim_done_bus = 1'b1;
    tick();
    b.trim_done_bus = 1'b0;
  endtask
  task automatic push(input int c, input logic is_end, input int cnt);
    exp_q.push_back('{cyc: c, is_end: is_end, cnt: 5'(cnt)});
  endtask
  task automatic start_run(output int c0);
    tick();
    c0 = cyc;
    b.start_trim = 1'b1;
    tick();
    b.start_trim = 1'b0;
  endtask
  task automatic test_reset();
    b.osc_auto_trim_mopshub = 1'b0; b.start_trim = 1'b0; b.trim_done_bus = 1'b0;
    #2 rst = 1'b0;
    #1;
    tests++; if (b.power_bus_en !== 1'b0) begin fails++; $display("FAIL reset_pwr got=%b exp=0", b.power_bus_en); end
    tests++; if (b.power_bus_cnt !== 5'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", b.power_bus_cnt); end
    tests++; if (b.start_trim_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got=%b exp=0", b.start_trim_ack); end
    tests++; if (b.end_trim_bus !== 1'b0) begin fails++; $display("FAIL reset_end got=%b exp=0", b.end_trim_bus); end
    tests++; if (b.done_trim_osc !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", b.done_trim_osc); end
    tests++; if (b.trim_timeout_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", b.trim_timeout_err); end
    tests++; if (b.bus_fail_mask !== 32'h0) begin fails++; $display("FAIL reset_mask got=%h exp=0", b.bus_fail_mask); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    b.osc_auto_trim_mopshub = 1'b1;
    repeat (3) tick();
    tests++; if (b.power_bus_en !== 1'b0) begin fails++; $display("FAIL idle_pwr got=%b exp=0", b.power_bus_en); end
  endtask
  task automatic test_bypass();
    int c0;
    b.osc_auto_trim_mopshub = 1'b0;
    pwr_seen = 1'b0; ack_seen = 1'b0;
    tick();
    c0 = cyc;
    tests++; if (b.done_trim_osc !== 1'b0) begin fails++; $display("FAIL bypass_done_before got=%b exp=0", b.done_trim_osc); end
    b.start_trim = 1'b1;
    tick();
    b.start_trim = 1'b0;
    tests++; if (b.done_trim_osc !== 1'b1) begin fails++; $display("FAIL bypass_done got=%b exp=1", b.done_trim_osc); end
    goto(c0 + 12);
    tests++; if (pwr_seen !== 1'b0) begin fails++; $display("FAIL bypass_pwr_seen got=%b exp=0", pwr_seen); end
    tests++; if (ack_seen !== 1'b0) begin fails++; $display("FAIL bypass_ack_seen got=%b exp=0", ack_seen); end
    b.osc_auto_trim_mopshub = 1'b1;
  endtask
  task automatic test_nominal();
    int c0;
    start_run(c0);
    push(c0 + 5, 0, 0); push(c0 + 11, 1, 0);
    push(c0 + 16, 0, 1); push(c0 + 22, 1, 1);
    push(c0 + 27, 0, 2); push(c0 + 33, 1, 2);
    tests++; if (b.power_bus_en !== 1'b1 || b.power_bus_cnt !== 5'd0) begin fails++; $display("FAIL nom_first_pwr got=%b/%0d exp=1/0", b.power_bus_en, b.power_bus_cnt); end
    pulse_done(c0 + 10);
    pulse_done(c0 + 21);
    pulse_done(c0 + 32);
    goto(c0 + 33);
    tests++; if (b.done_trim_osc !== 1'b0) begin fails++; $display("FAIL nom_done_early got=%b exp=0", b.done_trim_osc); end
    goto(c0 + 34);
    tests++; if (b.done_trim_osc !== 1'b1) begin fails++; $display("FAIL nom_done got=%b exp=1", b.done_trim_osc); end
    tests++; if (b.bus_fail_mask !== 32'h0) begin fails++; $display("FAIL nom_mask got=%h exp=0", b.bus_fail_mask); end
    tests++; if (b.power_bus_cnt !== 5'd2) begin fails++; $display("FAIL nom_cnt_hold got=%0d exp=2", b.power_bus_cnt); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL nom_missing got=%0d pending exp=0", exp_q.size()); end
    exp_q.delete();
  endtask
  task automatic test_timeout();
    int c0;
    start_run(c0);
    tests++; if (b.done_trim_osc !== 1'b0) begin fails++; $display("FAIL to_done_clear got=%b exp=0", b.done_trim_osc); end
    push(c0 + 5, 0, 0); push(c0 + 11, 1, 0);
    push(c0 + 16, 0, 1); push(c0 + 36, 1, 1);
    push(c0 + 41, 0, 2); push(c0 + 47, 1, 2);
    pulse_done(c0 + 10);
    goto(c0 + 35);
    tests++; if (b.trim_timeout_err !== 1'b0) begin fails++; $display("FAIL to_err_early got=%b exp=0", b.trim_timeout_err); end
    goto(c0 + 36);
    tests++; if (b.bus_fail_mask !== 32'h2) begin fails++; $display("FAIL to_mask got=%h exp=2", b.bus_fail_mask); end
    tests++; if (b.trim_timeout_err !== 1'b1) begin fails++; $display("FAIL to_err got=%b exp=1", b.trim_timeout_err); end
    tests++; if (b.power_bus_en !== 1'b0) begin fails++; $display("FAIL to_next_pwr got=%b exp=0", b.power_bus_en); end
    goto(c0 + 37);
    tests++; if (b.power_bus_en !== 1'b1 || b.power_bus_cnt !== 5'd2) begin fails++; $display("FAIL to_bus2_pwr got=%b/%0d exp=1/2", b.power_bus_en, b.power_bus_cnt); end
    pulse_done(c0 + 46);
    goto(c0 + 48);
    tests++; if (b.done_trim_osc !== 1'b1) begin fails++; $display("FAIL to_done got=%b exp=1", b.done_trim_osc); end
    tests++; if (b.bus_fail_mask !== 32'h2 || b.trim_timeout_err !== 1'b1) begin fails++; $display("FAIL to_final got=%h/%b exp=2/1", b.bus_fail_mask, b.trim_timeout_err); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL to_missing got=%0d pending exp=0", exp_q.size()); end
    exp_q.delete();
  endtask
  task automatic test_abort();
    int c0;
    start_run(c0);
    push(c0 + 5, 0, 0); push(c0 + 11, 1, 0); push(c0 + 16, 0, 1);
    pulse_done(c0 + 10);
    goto(c0 + 20);
    tests++; if (b.power_bus_en !== 1'b1 || b.done_trim_osc !== 1'b0) begin fails++; $display("FAIL ab_wait got=%b/%b exp=1/0", b.power_bus_en, b.done_trim_osc); end
    b.osc_auto_trim_mopshub = 1'b0;
    tick();
    b.osc_auto_trim_mopshub = 1'b1;
    tests++; if (b.power_bus_en !== 1'b0) begin fails++; $display("FAIL ab_pwr got=%b exp=0", b.power_bus_en); end
    tests++; if (b.done_trim_osc !== 1'b1) begin fails++; $display("FAIL ab_done got=%b exp=1", b.done_trim_osc); end
    tests++; if (b.bus_fail_mask !== 32'h0 || b.trim_timeout_err !== 1'b0) begin fails++; $display("FAIL ab_mask got=%h/%b exp=0/0", b.bus_fail_mask, b.trim_timeout_err); end
    tests++; if (b.power_bus_cnt !== 5'd1) begin fails++; $display("FAIL ab_cnt got=%0d exp=1", b.power_bus_cnt); end
    goto(c0 + 45);
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL ab_missing got=%0d pending exp=0", exp_q.size()); end
    exp_q.delete();
  endtask
  task automatic test_collision();
    int c0;
    start_run(c0);
    push(c0 + 5, 0, 0); push(c0 + 25, 1, 0);
    push(c0 + 30, 0, 1); push(c0 + 36, 1, 1);
    push(c0 + 41, 0, 2); push(c0 + 47, 1, 2);
    pulse_done(c0 + 2);
    pulse_done(c0 + 24);
    goto(c0 + 25);
    tests++; if (b.bus_fail_mask !== 32'h0 || b.trim_timeout_err !== 1'b0) begin fails++; $display("FAIL col_mask got=%h/%b exp=0/0", b.bus_fail_mask, b.trim_timeout_err); end
    pulse_done(c0 + 35);
    pulse_done(c0 + 46);
    goto(c0 + 48);
    tests++; if (b.done_trim_osc !== 1'b1 || b.bus_fail_mask !== 32'h0) begin fails++; $display("FAIL col_done got=%b/%h exp=1/0", b.done_trim_osc, b.bus_fail_mask); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL col_missing got=%0d pending exp=0", exp_q.size()); end
    exp_q.delete();
  endtask
  task automatic test_reset_mid();
    int c0, c1;
    start_run(c0);
    goto(c0 + 2);
    tests++; if (b.power_bus_en !== 1'b1) begin fails++; $display("FAIL rm_settle_pwr got=%b exp=1", b.power_bus_en); end
    #1 rst = 1'b0;
    #1;
    tests++; if (b.power_bus_en !== 1'b0) begin fails++; $display("FAIL rm_pwr got=%b exp=0", b.power_bus_en); end
    tests++; if (b.done_trim_osc !== 1'b0 || b.start_trim_ack !== 1'b0 || b.end_trim_bus !== 1'b0) begin fails++; $display("FAIL rm_flags got=%b%b%b exp=000", b.done_trim_osc, b.start_trim_ack, b.end_trim_bus); end
    rst = 1'b1;
    start_run(c1);
    push(c1 + 5, 0, 0);
    tests++; if (b.power_bus_en !== 1'b1 || b.power_bus_cnt !== 5'd0) begin fails++; $display("FAIL rm_restart got=%b/%0d exp=1/0", b.power_bus_en, b.power_bus_cnt); end
    goto(c1 + 7);
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rm_missing got=%0d pending exp=0", exp_q.size()); end
    exp_q.delete();
  endtask
  initial begin
    test_reset();
    test_bypass();
    test_nominal();
    test_timeout();
    test_abort();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
